// File: rtl/mips_pc_unit_pkg.sv
// Shared types and constants for the program-counter / fetch sequencing stage.
package mips_pc_pkg;

    typedef enum logic [1:0] {
        NONE     = 2'd0,
        BRANCH   = 2'd1,
        JUMP     = 2'd2,
        JUMP_REG = 2'd3
    } redirect_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DELAY  = 2'd1,
        HALTED = 2'd2
    } pc_state_t;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] HALT_ADDR_DEFAULT    = 32'h0000_0000;

endpackage

// File: rtl/mips_pc_unit_if.sv
// Decode-side redirect requests in, fetch address and CPU status out.
interface mips_pc_unit_if;
    import mips_pc_pkg::*;

    logic        clk_enable;
    redirect_t   redirect_type;
    logic        branch_cond;
    logic [15:0] imm16;
    logic [25:0] index26;
    logic [31:0] rs_value;
    logic [31:0] instr_address;
    logic [31:0] link_address;
    logic        in_delay_slot;
    logic        active;
    logic        addr_error;

    // Decode/execute side drives redirects and samples the fetch address.
    modport master (
        output clk_enable, redirect_type, branch_cond, imm16, index26, rs_value,
        input  instr_address, link_address, in_delay_slot, active, addr_error
    );

    // PC unit side.
    modport slave (
        input  clk_enable, redirect_type, branch_cond, imm16, index26, rs_value,
        output instr_address, link_address, in_delay_slot, active, addr_error
    );

endinterface

// File: rtl/mips_pc_unit_branch_target.sv
// Redirect target computation for branch, jump and jump-register forms.
module mips_branch_target
    import mips_pc_pkg::*;
(
    input  logic [31:0] i_a4,
    input  redirect_t   i_redirect_type,
    input  logic [15:0] i_imm16,
    input  logic [25:0] i_index26,
    input  logic [31:0] i_rs_value,
    output logic [31:0] o_target
);

    // Branch offsets are relative to the delay-slot address; J keeps its 256 MB region.
    always_comb begin
        o_target = 32'h0000_0000;
        case (i_redirect_type)
            BRANCH:   o_target = i_a4 + {{14{i_imm16[15]}}, i_imm16, 2'b00};
            JUMP:     o_target = {i_a4[31:28], i_index26, 2'b00};
            JUMP_REG: o_target = i_rs_value;
            default:  o_target = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mips_pc_unit.sv
// Program counter with branch-delay-slot sequencing, halt-on-zero and JR alignment fault.
module mips_pc_unit
    import mips_pc_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEFAULT
)(
    input  logic          clk,
    input  logic          reset,
    mips_pc_unit_if.slave bus
);

    pc_state_t   r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pending;
    logic        r_active;
    logic        r_delay;
    logic        r_addr_error;
    // Set when a misaligned JR was seen; the following edge halts without moving the PC.
    logic        r_fault;

    logic [31:0] w_a4;
    logic [31:0] w_target;
    logic        w_misaligned;
    logic        w_taken;

    assign w_a4 = r_pc + 32'd4;

    mips_branch_target u_target (
        .i_a4            (w_a4),
        .i_redirect_type (bus.redirect_type),
        .i_imm16         (bus.imm16),
        .i_index26       (bus.index26),
        .i_rs_value      (bus.rs_value),
        .o_target        (w_target)
    );

    // Classify the redirect presented this cycle.
    always_comb begin
        w_misaligned = (bus.redirect_type == JUMP_REG) && (bus.rs_value[1:0] != 2'b00);
        w_taken      = 1'b0;
        case (bus.redirect_type)
            BRANCH:   w_taken = bus.branch_cond;
            JUMP:     w_taken = 1'b1;
            JUMP_REG: w_taken = !w_misaligned;
            default:  w_taken = 1'b0;
        endcase
    end

    // Fetch sequencer: RUN accepts redirects, DELAY fetches the slot then jumps, HALTED is terminal.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= RUN;
            r_pc         <= RESET_VECTOR;
            r_pending    <= 32'h0000_0000;
            r_active     <= 1'b1;
            r_delay      <= 1'b0;
            r_addr_error <= 1'b0;
            r_fault      <= 1'b0;
        end else if (bus.clk_enable) begin
            r_addr_error <= 1'b0;
            case (r_state)
                RUN: begin
                    r_pc <= w_a4;
                    if (w_misaligned) begin
                        r_addr_error <= 1'b1;
                        r_fault      <= 1'b1;
                        r_state      <= DELAY;
                    end else if (w_taken) begin
                        r_pending <= w_target;
                        r_delay   <= 1'b1;
                        r_state   <= DELAY;
                    end
                end
                DELAY: begin
                    // Redirects arriving here are ignored: the first redirect wins.
                    r_delay <= 1'b0;
                    if (r_fault) begin
                        r_active <= 1'b0;
                        r_state  <= HALTED;
                    end else begin
                        r_pc <= r_pending;
                        if (r_pending == HALT_ADDR) begin
                            r_active <= 1'b0;
                            r_state  <= HALTED;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                HALTED: begin
                    r_active <= 1'b0;
                end
                default: begin
                    r_active <= 1'b0;
                    r_state  <= HALTED;
                end
            endcase
        end
    end

    assign bus.instr_address = r_pc;
    assign bus.link_address  = r_pc + 32'd8;
    assign bus.in_delay_slot = r_delay;
    assign bus.active        = r_active;
    // A frozen pipeline must not report a fault.
    assign bus.addr_error    = r_addr_error & bus.clk_enable;

endmodule

// File: tb/tb_mips_pc_unit.sv
// Directed-vector bench for mips_pc_unit with a queue-based scoreboard.
module tb_mips_pc_unit;
    import mips_pc_pkg::*;

    localparam logic [31:0] RV = 32'hBFC0_0000;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        dly;
        logic        act;
        logic        aerr;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    exp_t q[$];
    event ev_async;

    mips_pc_unit_if bus ();

    mips_pc_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string nm, string fld, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s actual=%08h required=%08h", nm, fld, act, exp);
        end
    endtask

    // Monitor: after each clock edge (or an asynchronous event) pop one expectation and compare.
    initial begin
        forever begin
            @(posedge clk or ev_async);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk(e.name, "pc",   bus.instr_address, e.pc);
                chk(e.name, "link", bus.link_address,  e.pc + 32'd8);
                chk(e.name, "dly",  {31'd0, bus.in_delay_slot}, {31'd0, e.dly});
                chk(e.name, "act",  {31'd0, bus.active},        {31'd0, e.act});
                chk(e.name, "aerr", {31'd0, bus.addr_error},    {31'd0, e.aerr});
            end
        end
    end

    // Starts and ends on a falling edge; one rising edge per call.
    task automatic step(string nm, redirect_t rt, logic bc, logic [15:0] imm, logic [25:0] idx,
                        logic [31:0] rs, logic ce,
                        logic [31:0] epc, logic edly, logic eact, logic eaerr);
        bus.redirect_type = rt;
        bus.branch_cond   = bc;
        bus.imm16         = imm;
        bus.index26       = idx;
        bus.rs_value      = rs;
        bus.clk_enable    = ce;
        @(posedge clk);
        q.push_back('{nm, epc, edly, eact, eaerr});
        @(negedge clk);
    endtask

    task automatic idle(string nm, logic [31:0] epc, logic edly, logic eact);
        step(nm, NONE, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1, epc, edly, eact, 1'b0);
    endtask

    // Asynchronous reset checked before any clock edge, then released on a falling edge.
    task automatic do_reset(string nm);
        bus.redirect_type = NONE;
        bus.branch_cond   = 1'b0;
        bus.imm16         = 16'h0;
        bus.index26       = 26'h0;
        bus.rs_value      = 32'h0;
        bus.clk_enable    = 1'b1;
        reset             = 1'b1;
        q.push_back('{nm, RV, 1'b0, 1'b1, 1'b0});
        -> ev_async;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.redirect_type = NONE;
        bus.branch_cond   = 1'b0;
        bus.imm16         = 16'h0;
        bus.index26       = 26'h0;
        bus.rs_value      = 32'h0;
        bus.clk_enable    = 1'b1;
        @(negedge clk);

        // Sequential fetch
        do_reset("rst_a");
        idle("seq1", 32'hBFC0_0004, 1'b0, 1'b1);
        idle("seq2", 32'hBFC0_0008, 1'b0, 1'b1);
        idle("seq3", 32'hBFC0_000C, 1'b0, 1'b1);

        // Taken forward branch
        do_reset("rst_b");
        idle("b_pre1", 32'hBFC0_0004, 1'b0, 1'b1);
        idle("b_pre2", 32'hBFC0_0008, 1'b0, 1'b1);
        step("b_taken", BRANCH, 1'b1, 16'h0020, 26'h0, 32'h0, 1'b1, 32'hBFC0_000C, 1'b1, 1'b1, 1'b0);
        idle("b_tgt",   32'hBFC0_008C, 1'b0, 1'b1);
        idle("b_after", 32'hBFC0_0090, 1'b0, 1'b1);

        // Not-taken branch
        do_reset("rst_c");
        idle("nt_pre1", 32'hBFC0_0004, 1'b0, 1'b1);
        idle("nt_pre2", 32'hBFC0_0008, 1'b0, 1'b1);
        step("nt_br", BRANCH, 1'b0, 16'h0020, 26'h0, 32'h0, 1'b1, 32'hBFC0_000C, 1'b0, 1'b1, 1'b0);
        idle("nt_next", 32'hBFC0_0010, 1'b0, 1'b1);

        // Backward branch by -4 from the delay-slot address
        do_reset("rst_d");
        idle("bk_pre1", 32'hBFC0_0004, 1'b0, 1'b1);
        idle("bk_pre2", 32'hBFC0_0008, 1'b0, 1'b1);
        idle("bk_pre3", 32'hBFC0_000C, 1'b0, 1'b1);
        idle("bk_pre4", 32'hBFC0_0010, 1'b0, 1'b1);
        step("bk_br", BRANCH, 1'b1, 16'hFFFF, 26'h0, 32'h0, 1'b1, 32'hBFC0_0014, 1'b1, 1'b1, 1'b0);
        idle("bk_tgt", 32'hBFC0_0010, 1'b0, 1'b1);

        // JR to address 0 halts after the delay slot
        do_reset("rst_e");
        step("jr0", JUMP_REG, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1, 32'hBFC0_0004, 1'b1, 1'b1, 1'b0);
        idle("halt", 32'h0000_0000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) idle("halt_hold", 32'h0000_0000, 1'b0, 1'b0);
        step("halt_jmp", JUMP, 1'b0, 16'h0, 26'h0000040, 32'h0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0);

        // Redirect in the delay slot is ignored
        do_reset("rst_f");
        step("j", JUMP, 1'b0, 16'h0, 26'h0000040, 32'h0, 1'b1, 32'hBFC0_0004, 1'b1, 1'b1, 1'b0);
        step("j_slot_br", BRANCH, 1'b1, 16'h0020, 26'h0, 32'h0, 1'b1, 32'hB000_0100, 1'b0, 1'b1, 1'b0);
        idle("j_after", 32'hB000_0104, 1'b0, 1'b1);

        // Misaligned JR: one-cycle error pulse, masked while frozen, then halt with PC unchanged
        do_reset("rst_g");
        step("jr_mis", JUMP_REG, 1'b0, 16'h0, 26'h0, 32'h0000_0012, 1'b1, 32'hBFC0_0004, 1'b0, 1'b1, 1'b1);
        step("jr_mis_frz", NONE, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 32'hBFC0_0004, 1'b0, 1'b1, 1'b0);
        idle("jr_mis_halt", 32'hBFC0_0004, 1'b0, 1'b0);
        idle("jr_mis_hold", 32'hBFC0_0004, 1'b0, 1'b0);

        // Freeze in DELAY, then resume into the jump target
        do_reset("rst_i");
        step("fz_j", JUMP, 1'b0, 16'h0, 26'h0000040, 32'h0, 1'b1, 32'hBFC0_0004, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++)
            step("fz_hold", BRANCH, 1'b1, 16'h0020, 26'h0, 32'h0, 1'b0, 32'hBFC0_0004, 1'b1, 1'b1, 1'b0);
        idle("fz_resume", 32'hB000_0100, 1'b0, 1'b1);

        // Freeze in DELAY for four edges, then reset mid-DELAY drops the pending target
        do_reset("rst_h");
        step("rd_j", JUMP, 1'b0, 16'h0, 26'h0000040, 32'h0, 1'b1, 32'hBFC0_0004, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            step("rd_frz", NONE, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 32'hBFC0_0004, 1'b1, 1'b1, 1'b0);
        do_reset("rst_mid_delay");
        idle("rd_after", 32'hBFC0_0004, 1'b0, 1'b1);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain actual=%0d pending required=0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_pc_unit.md
Name: mips_pc_unit

Overview:
Program-counter and fetch-sequencing stage of mips_cpu_harvard. It sits directly upstream of the instruction port: it drives instr_address and consumes redirect requests from decode/execute. It implements MIPS branch-delay-slot semantics, computes branch and jump targets, produces the link address, and owns the CPU `active` flag, including halting on a jump to address 0.

Parameters:
RESET_VECTOR, 32'hBFC00000, address fetched first after reset.
HALT_ADDR, 32'h00000000, a taken redirect to this address halts the CPU once the delay slot completes.

Ports:
clk  in  1  system clock, rising-edge.
reset  in  1  asynchronous, active-high reset.
clk_enable  in  1  when low, all state is frozen.
redirect_type  in  2  from decode: NONE=0, BRANCH=1, JUMP=2, JUMP_REG=3.
branch_cond  in  1  branch condition result; used only when redirect_type is BRANCH.
imm16  in  16  branch offset field.
index26  in  26  J/JAL target field.
rs_value  in  32  register value for JR/JALR.
instr_address  out  32  current fetch PC.
link_address  out  32  instr_address + 8, for JAL/JALR/BxxAL.
in_delay_slot  out  1  the current instruction is a delay slot.
active  out  1  high while the CPU is running.
addr_error  out  1  one-cycle pulse on a misaligned JR target.

Behaviour:
- Reset (asynchronous): instr_address=RESET_VECTOR, state=RUN, active=1, in_delay_slot=0, addr_error=0, pending target register=0.
- All updates happen on the rising clk edge when clk_enable=1. When clk_enable=0, every register holds and addr_error is forced to 0.
- States are RUN, DELAY and HALTED. Let A = instr_address and A4 = A+4. All arithmetic is 32-bit and wraps modulo 2^32.
- Target computation (combinational):
  - BRANCH: A4 + ({{14{imm16[15]}}, imm16, 2'b00}).
  - JUMP: {A4[31:28], index26, 2'b00}.
  - JUMP_REG: rs_value.
- A redirect is taken when redirect_type is JUMP or JUMP_REG, or when it is BRANCH and branch_cond=1.
- RUN:
  - Redirect taken: pending <= target, PC <= A4, go to DELAY, in_delay_slot <= 1.
  - Otherwise: PC <= A4 and stay in RUN.
- DELAY:
  - PC <= pending, in_delay_slot <= 0.
  - If pending == HALT_ADDR: go to HALTED and set active <= 0. Otherwise go to RUN.
  - Any redirect presented while in DELAY is ignored; the first redirect wins.
- HALTED: PC holds at HALT_ADDR and active stays 0. Only reset leaves this state.
- JUMP_REG with rs_value[1:0] != 0 while in RUN:
  - addr_error pulses for one cycle and the redirect is not taken.
  - PC <= A4, then the next edge goes to HALTED (active=0, PC unchanged).
- The halt check applies to the computed target of every redirect type.
- Reset asserted mid-operation, including in DELAY or HALTED, discards the pending target immediately.
- link_address is combinational: instr_address + 8.

Decomposition:
- Shared package mips_pc_pkg: redirect_t enum (NONE, BRANCH, JUMP, JUMP_REG), pc_state_t enum (RUN, DELAY, HALTED), RESET_VECTOR_DEFAULT constant.
- One natural combinational sub-module, mips_branch_target: inputs A4, redirect_type, imm16, index26, rs_value; output target.
- The state machine and registers stay in mips_pc_unit.

Test Plan:
- Reset, then 3 edges with redirect_type=NONE -> instr_address goes BFC00000, BFC00004, BFC00008, BFC0000C; active=1; link_address=BFC00014 at BFC0000C.
- At BFC00008: BRANCH, branch_cond=1, imm16=0x0020 -> next BFC0000C with in_delay_slot=1, then BFC0008C. The same stimulus with branch_cond=0 -> BFC0000C, then BFC00010.
- At BFC00010: BRANCH taken, imm16=0xFFFF -> BFC00014, then BFC00010 (backward wrap of offset).
- At BFC00000: JUMP_REG with rs_value=0x00000000 -> BFC00004, then 00000000 with active=0; 5 further edges -> PC stays 0 and active stays 0.
- In the delay slot after a JUMP with index26=0x0000040 (target B0000100): present BRANCH taken -> it is ignored and PC = B0000100. Separately, JUMP_REG with rs_value=0x12 -> addr_error pulses 1 cycle, then halt.
- Hold clk_enable=0 for 4 edges while in DELAY -> instr_address and state frozen. Assert reset mid-DELAY -> immediately BFC00000, in_delay_slot=0, active=1.
